ook_beacon_tx: RTL and testbench

- Parametrised on-off-keyed (AM) serial beacon transmitter.
- Captures a DATA_W-bit payload word and sends one bit per symbol period as gated carrier bursts on a single antenna output: a marker burst in every symbol, plus a data burst when the bit is 1.
- Generalises the fixed 128-bit, fixed-rate beacon with configurable width, symbol/carrier timing, preamble, bit order, repeat count, abort and status outputs.
- Sits beside the cipher core; driven only by the local clock.

---
 rtl/ook_beacon_tx.sv | 165 ++++++++++++++++
 tb/tb_ook_beacon_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ook_beacon_tx.sv
`default_nettype none
// ============================================================================
// Module   : ook_beacon_tx
// Purpose  : On-off-keyed beacon: marker burst every symbol, data burst on '1'.
// Revision : 1.0
// ============================================================================
module ook_beacon_tx #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned SLOT_CYC     = 4096,
  parameter int unsigned CARRIER_HALF = 8,
  parameter int unsigned PREAMBLE_LEN = 2,
  parameter int unsigned REPEAT       = 1,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         payload,
  input  logic                      load,
  input  logic                      abort,
  output logic                      antenna,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DATA_W)-1:0] bit_idx
);

  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int unsigned FW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  localparam logic [SW-1:0] C_SLOT_LAST  = SW'(SLOT_CYC - 1);
  localparam logic [SW-1:0] C_HALF       = SW'(CARRIER_HALF);
  localparam logic [PW-1:0] C_PRE_LAST   = PW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [BW-1:0] C_BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [FW-1:0] C_FRAME_LAST = FW'((REPEAT > 0) ? REPEAT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam state_t C_FIRST_STATE = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_DATA;

  state_t            state_q;
  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;
  logic [2:0]        slot_q, slot_d;
  logic [PW-1:0]     pre_cnt_q;
  logic [FW-1:0]     frame_q;
  logic [BW-1:0]     bit_idx_q;
  logic [DATA_W-1:0] shift_q, copy_q;
  logic              antenna_q, done_q;

  logic              w_sym_end, w_cur_bit, w_carrier, w_burst;
  logic [SW-1:0]     w_half_idx;
  logic [DATA_W-1:0] w_shifted;

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    slot_d     = slot_q;
    w_sym_end  = 1'b0;
    if (slot_cnt_q == C_SLOT_LAST) begin
      slot_cnt_d = '0;
      slot_d     = slot_q + 3'd1;
      w_sym_end  = (slot_q == 3'd7);
    end
  end

  // Slots are whole carrier periods, so each slot opens on a high half-cycle.
  assign w_half_idx = slot_cnt_q / C_HALF;
  assign w_carrier  = ~w_half_idx[0];
  assign w_cur_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign w_shifted  = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};

  always_comb begin
    w_burst = 1'b0;
    case (state_q)
      S_PREAMBLE: w_burst = (slot_q == 3'd0) || (slot_q == 3'd2);
      S_DATA:     w_burst = (slot_q == 3'd0) || ((slot_q == 3'd2) && w_cur_bit);
      default:    w_burst = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      slot_cnt_q <= '0;
      slot_q     <= '0;
      pre_cnt_q  <= '0;
      frame_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      copy_q     <= '0;
      antenna_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      antenna_q <= w_burst & w_carrier;
      if (state_q == S_IDLE) begin
        if (load && !abort) begin
          shift_q    <= payload;
          copy_q     <= payload;
          slot_cnt_q <= '0;
          slot_q     <= '0;
          pre_cnt_q  <= '0;
          frame_q    <= '0;
          bit_idx_q  <= '0;
          state_q    <= C_FIRST_STATE;
        end
      end else if (abort) begin
        state_q    <= S_IDLE;
        slot_cnt_q <= '0;
        slot_q     <= '0;
        pre_cnt_q  <= '0;
        bit_idx_q  <= '0;
      end else begin
        slot_cnt_q <= slot_cnt_d;
        slot_q     <= slot_d;
        if (w_sym_end) begin
          case (state_q)
            S_PREAMBLE: begin
              if (pre_cnt_q == C_PRE_LAST) begin
                pre_cnt_q <= '0;
                state_q   <= S_DATA;
              end else begin
                pre_cnt_q <= pre_cnt_q + 1'b1;
              end
            end
            S_DATA: begin
              shift_q <= w_shifted;
              if (bit_idx_q == C_BIT_LAST) begin
                bit_idx_q <= '0;
                state_q   <= S_GAP;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
            S_GAP: begin
              // frame_q saturates so an endless repeat never wraps it.
              if ((REPEAT == 0) || (frame_q != C_FRAME_LAST)) begin
                if (frame_q != '1) begin
                  frame_q <= frame_q + 1'b1;
                end
                shift_q <= copy_q;
                state_q <= C_FIRST_STATE;
              end else begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign antenna = antenna_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_ook_beacon_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ook_beacon_tx
// Purpose  : Scoreboard bench for ook_beacon_tx (8-bit, 64-cycle symbols).
// Revision : 1.0
// ============================================================================
module tb_ook_beacon_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pl  [3];
  logic       ld  [3];
  logic       ab  [3];
  logic       ant [3];
  logic       bsy [3];
  logic       dn  [3];
  logic [2:0] bi  [3];

  always #5 clk = ~clk;

  ook_beacon_tx #(.DATA_W(8), .SLOT_CYC(8), .CARRIER_HALF(2), .PREAMBLE_LEN(1),
                  .REPEAT(1), .MSB_FIRST(1'b0)) u_dut_base (
    .clk(clk), .rst(rst), .payload(pl[0]), .load(ld[0]), .abort(ab[0]),
    .antenna(ant[0]), .busy(bsy[0]), .done(dn[0]), .bit_idx(bi[0]));

  ook_beacon_tx #(.DATA_W(8), .SLOT_CYC(8), .CARRIER_HALF(2), .PREAMBLE_LEN(1),
                  .REPEAT(1), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .payload(pl[1]), .load(ld[1]), .abort(ab[1]),
    .antenna(ant[1]), .busy(bsy[1]), .done(dn[1]), .bit_idx(bi[1]));

  ook_beacon_tx #(.DATA_W(8), .SLOT_CYC(8), .CARRIER_HALF(2), .PREAMBLE_LEN(1),
                  .REPEAT(3), .MSB_FIRST(1'b0)) u_dut_rep (
    .clk(clk), .rst(rst), .payload(pl[2]), .load(ld[2]), .abort(ab[2]),
    .antenna(ant[2]), .busy(bsy[2]), .done(dn[2]), .bit_idx(bi[2]));

  typedef struct {
    int         sel;
    int         tid;
    int         cyc;
    logic [5:0] exp;
  } ent_t;

  ent_t       sb[$];
  ent_t       m_e;
  logic [5:0] m_act;
  int         checks = 0;
  int         errors = 0;

  function automatic string tname(int tid);
    case (tid)
      0:       return "reset";
      1:       return "idle";
      2:       return "basic_a5";
      3:       return "msb_first_01";
      4:       return "repeat3_ff";
      5:       return "load_while_busy";
      6:       return "abort";
      7:       return "abort_load_idle";
      8:       return "post_reset_idle";
      9:       return "pre_reset_frame";
      10:      return "async_reset";
      default: return "other";
    endcase
  endfunction

  // Antenna drive derived from the internal state during frame cycle x (x>=1).
  function automatic logic burst_at(int x, logic [7:0] p, bit msb);
    int   k, sym, w, slot, sc;
    logic car, b, bitv;
    k    = (x - 1) % 640;
    sym  = k / 64;
    w    = k % 64;
    slot = w / 8;
    sc   = w % 8;
    car  = ((sc / 2) % 2) == 0;
    if (sym == 0) begin
      b = (slot == 0) || (slot == 2);
    end else if (sym <= 8) begin
      bitv = msb ? p[8 - sym] : p[sym - 1];
      b    = (slot == 0) || ((slot == 2) && bitv);
    end else begin
      b = 1'b0;
    end
    return b & car;
  endfunction

  // Expected {antenna, busy, done, bit_idx} for cycle c after load acceptance.
  function automatic logic [5:0] model(int c, logic [7:0] p, bit msb, int rep, int abt);
    int         tot, k, sym;
    logic       a, bs, d;
    logic [2:0] idx;
    tot = 640 * rep;
    bs  = (c >= 1) && (c <= tot);
    d   = (c == tot + 1);
    idx = 3'd0;
    a   = 1'b0;
    if (bs) begin
      k   = (c - 1) % 640;
      sym = k / 64;
      if (sym >= 1 && sym <= 8) idx = 3'(sym - 1);
    end
    if ((c - 1 >= 1) && (c - 1 <= tot)) a = burst_at(c - 1, p, msb);
    if (abt > 0 && c > abt) begin
      bs  = 1'b0;
      d   = 1'b0;
      idx = 3'd0;
      if (c > abt + 1) a = 1'b0;
    end
    return {a, bs, d, idx};
  endfunction

  task automatic push(int sel, int tid, int cyc, logic [5:0] exp);
    sb.push_back(ent_t'{sel, tid, cyc, exp});
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(int tid);
    logic [5:0] act;
    for (int s = 0; s < 3; s++) begin
      act = {ant[s], bsy[s], dn[s], bi[s]};
      checks++;
      if (act !== 6'b0) begin
        errors++;
        $display("FAIL %s dut%0d got ant/busy/done/idx=%b required=%b", tname(tid), s, act, 6'b0);
      end
    end
  endtask

  // Called at posedge+1; load accepted at the next edge.
  task automatic run_frame(int sel, int tid, logic [7:0] p, bit msb, int rep,
                           int ab_at, int ld2_at, int ncyc);
    pl[sel] = p;
    ld[sel] = 1'b1;
    @(posedge clk);
    #1;
    ld[sel] = 1'b0;
    for (int c = 1; c <= ncyc; c++) push(sel, tid, c, model(c, p, msb, rep, ab_at));
    for (int c = 1; c <= ncyc; c++) begin
      if (c == ld2_at) begin
        pl[sel] = 8'h00;
        ld[sel] = 1'b1;
      end
      if (c == ab_at) ab[sel] = 1'b1;
      @(posedge clk);
      #1;
      ld[sel] = 1'b0;
      ab[sel] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e   = sb.pop_front();
      m_act = {ant[m_e.sel], bsy[m_e.sel], dn[m_e.sel], bi[m_e.sel]};
      checks++;
      if (m_act !== m_e.exp) begin
        errors++;
        $display("FAIL %s dut%0d cyc %0d got ant/busy/done/idx=%b required=%b",
                 tname(m_e.tid), m_e.sel, m_e.cyc, m_act, m_e.exp);
      end
    end
  end

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pl[s] = 8'h00;
      ld[s] = 1'b0;
      ab[s] = 1'b0;
    end
    #1;
    check_now(10);
    for (int s = 0; s < 3; s++) push(s, 0, s, 6'b0);
    wait_cyc(3);
    rst = 1'b1;

    for (int c = 1; c <= 100; c++) push(0, 1, c, 6'b0);
    wait_cyc(100);

    run_frame(0, 2, 8'hA5, 1'b0, 1, 0, 0, 650);
    run_frame(1, 3, 8'h01, 1'b1, 1, 0, 0, 650);
    run_frame(2, 4, 8'hFF, 1'b0, 3, 0, 0, 1930);
    run_frame(0, 5, 8'hA5, 1'b0, 1, 0, 200, 650);
    run_frame(0, 6, 8'hA5, 1'b0, 1, 300, 0, 310);

    for (int c = 1; c <= 6; c++) push(0, 7, c, 6'b0);
    pl[0] = 8'h3C;
    ld[0] = 1'b1;
    ab[0] = 1'b1;
    wait_cyc(1);
    ld[0] = 1'b0;
    ab[0] = 1'b0;
    wait_cyc(5);

    run_frame(0, 9, 8'hA5, 1'b0, 1, 0, 0, 399);
    #2;
    rst = 1'b0;
    #1;
    check_now(10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 20; c++) push(0, 8, c, 6'b0);
    wait_cyc(20);

    wait_cyc(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
